// File: rtl/tx_arbiter_if.sv
// Signal bundle between the TX arbiter, the event FIFO, the config path and the UART.
// The arbiter sits on the slave modport; the surrounding logic drives the master side.
interface tx_arbiter_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-2:0] cfg_data;
    logic             cfg_req;
    logic [WIDTH-2:0] fifo_data;
    logic             fifo_empty;
    logic             tx_busy;
    logic             read_fifo_n;
    logic [WIDTH-2:0] tx_data;
    logic             ld_tx_data;
    logic             cfg_pending;
    logic             arb_busy;
    logic             tx_timeout;
    logic [7:0]       cfg_drops;
    logic [15:0]      tx_words;

    modport slave (
        input  cfg_data,
        input  cfg_req,
        input  fifo_data,
        input  fifo_empty,
        input  tx_busy,
        output read_fifo_n,
        output tx_data,
        output ld_tx_data,
        output cfg_pending,
        output arb_busy,
        output tx_timeout,
        output cfg_drops,
        output tx_words
    );

    modport master (
        output cfg_data,
        output cfg_req,
        output fifo_data,
        output fifo_empty,
        output tx_busy,
        input  read_fifo_n,
        input  tx_data,
        input  ld_tx_data,
        input  cfg_pending,
        input  arb_busy,
        input  tx_timeout,
        input  cfg_drops,
        input  tx_words
    );
endinterface

// File: rtl/tx_arbiter.sv
// UART TX arbiter: config words take priority over FIFO drain, with a burst limit.
// Define TX_ARB_STATS_EN to build the cfg_drops / tx_words counters; otherwise they read 0.
module tx_arbiter #(
    parameter int WIDTH         = 64,
    parameter int FIFO_LATENCY  = 2,
    parameter int MAX_CFG_BURST = 4,
    parameter int BUSY_TIMEOUT  = 15
) (
    input logic         clk,
    input logic         reset_n,
    tx_arbiter_if.slave bus
);
    localparam logic [3:0] LAT   = 4'(FIFO_LATENCY);
    localparam logic [3:0] BURST = 4'(MAX_CFG_BURST);
    localparam logic [3:0] TMO   = 4'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIFO_WAIT,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t           r_state;
    logic [WIDTH-2:0] r_hold;
    logic [WIDTH-2:0] r_tx_data;
    logic             r_cfg_pending;
    logic             r_read_fifo_n;
    logic             r_ld;
    logic             r_arb_busy;
    logic             r_timeout;
    logic [3:0]       r_burst;
    logic [3:0]       r_cnt;

    logic w_idle_free;
    logic w_cfg_go;
    logic w_fifo_go;

    // Config wins unless it has used up its burst while FIFO words wait.
    assign w_idle_free = (r_state == S_IDLE) && !bus.tx_busy;
    assign w_cfg_go    = w_idle_free && r_cfg_pending &&
                         ((r_burst < BURST) || bus.fifo_empty);
    assign w_fifo_go   = w_idle_free && !w_cfg_go && !bus.fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_hold        <= '0;
            r_tx_data     <= '0;
            r_cfg_pending <= 1'b0;
            r_read_fifo_n <= 1'b1;
            r_ld          <= 1'b0;
            r_arb_busy    <= 1'b0;
            r_timeout     <= 1'b0;
            r_burst       <= '0;
            r_cnt         <= '0;
        end else begin
            r_ld          <= 1'b0;
            r_read_fifo_n <= 1'b1;

            // A request landing on the consume cycle refills the slot.
            if (bus.cfg_req && (!r_cfg_pending || w_cfg_go)) begin
                r_hold        <= bus.cfg_data;
                r_cfg_pending <= 1'b1;
            end else if (w_cfg_go) begin
                r_cfg_pending <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_cfg_go) begin
                        r_tx_data  <= r_hold;
                        r_burst    <= bus.fifo_empty ? 4'd0 : r_burst + 4'd1;
                        r_arb_busy <= 1'b1;
                        r_state    <= S_LOAD;
                    end else if (w_fifo_go) begin
                        r_read_fifo_n <= 1'b0;
                        r_burst       <= '0;
                        r_cnt         <= 4'd1;
                        r_arb_busy    <= 1'b1;
                        r_state       <= S_FIFO_WAIT;
                    end
                end
                S_FIFO_WAIT: begin
                    if (r_cnt == LAT) begin
                        r_tx_data <= bus.fifo_data;
                        r_state   <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_LOAD: begin
                    r_ld    <= 1'b1;
                    r_cnt   <= 4'd1;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else if (r_cnt == TMO) begin
                        r_timeout  <= 1'b1;
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        r_arb_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.read_fifo_n = r_read_fifo_n;
    assign bus.tx_data     = r_tx_data;
    assign bus.ld_tx_data  = r_ld;
    assign bus.cfg_pending = r_cfg_pending;
    assign bus.arb_busy    = r_arb_busy;
    assign bus.tx_timeout  = r_timeout;

`ifdef TX_ARB_STATS_EN
    logic       w_drop;
    logic       w_load;
    logic [7:0]  r_drops;
    logic [15:0] r_words;

    assign w_drop = bus.cfg_req && r_cfg_pending && !w_cfg_go;
    assign w_load = (r_state == S_LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drops <= '0;
            r_words <= '0;
        end else begin
            if (w_drop && (r_drops != 8'hFF)) begin
                r_drops <= r_drops + 8'd1;
            end
            if (w_load) begin
                r_words <= r_words + 16'd1;
            end
        end
    end

    assign bus.cfg_drops = r_drops;
    assign bus.tx_words  = r_words;
`else
    assign bus.cfg_drops = '0;
    assign bus.tx_words  = '0;
`endif
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed-sequence bench for tx_arbiter with random payloads, a FIFO/UART model
// and a rule-level model of the config/FIFO grant order.
module tb_tx_arbiter;
    localparam int WIDTH = 64;
    localparam int FL    = 2;
    localparam int MAXB  = 4;
    localparam int TMO   = 15;
`ifdef TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [WIDTH-2:0] word_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tx_arbiter_if #(.WIDTH(WIDTH)) bus ();

    tx_arbiter #(
        .WIDTH(WIDTH),
        .FIFO_LATENCY(FL),
        .MAX_CFG_BURST(MAXB),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    word_t fmem [256];
    int    wr_ptr = 0;
    int    rd_ptr = 0;
    word_t txq [$];
    int    strobes = 0;
    int    bad_reads = 0;
    int    busy_cnt = 0;
    bit    force_busy = 1'b0;
    bit    uart_en = 1'b1;
    word_t pend_word;
    int    pend_cnt = 0;

    word_t mcfg [$];
    word_t mfifo [$];
    word_t expq [$];

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.tx_busy    = force_busy || (busy_cnt > 0);

    // FIFO with read latency, UART busy model, and capture of loaded words
    always begin
        @(posedge clk);
        #1;
        if (busy_cnt > 0) busy_cnt--;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) bus.fifo_data = pend_word;
        end
        if (reset_n && bus.ld_tx_data === 1'b1) begin
            txq.push_back(bus.tx_data);
            if (uart_en) busy_cnt = 10;
        end
        if (reset_n && bus.read_fifo_n === 1'b0) begin
            strobes++;
            if (wr_ptr == rd_ptr) begin
                bad_reads++;
            end else begin
                pend_word = fmem[rd_ptr];
                rd_ptr++;
                if (FL > 1) begin
                    bus.fifo_data = word_t'({$urandom, $urandom});
                    pend_cnt = FL - 1;
                end else begin
                    bus.fifo_data = pend_word;
                end
            end
        end
    end

    function automatic word_t rnd();
        return word_t'({$urandom, $urandom});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_fifo(input word_t w);
        fmem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic cfg_pulse(input word_t w);
        @(negedge clk);
        bus.cfg_data = w;
        bus.cfg_req = 1'b1;
        @(negedge clk);
        bus.cfg_req = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
        check("wait_tx", 64'(txq.size()), 64'(n));
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (bus.arb_busy || bus.tx_busy); i++) @(negedge clk);
        check("wait_idle", 64'(bus.arb_busy), 64'd0);
    endtask

    task automatic edges_to_ld(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ld_tx_data === 1'b1) break;
        end
    endtask

    // Grant order from the arbitration rule, every source ready at every decision
    task automatic model_order();
        int burst;
        burst = 0;
        expq.delete();
        while (mcfg.size() > 0 || mfifo.size() > 0) begin
            if (mcfg.size() > 0 && (burst < MAXB || mfifo.size() == 0)) begin
                expq.push_back(mcfg.pop_front());
                burst = (mfifo.size() == 0) ? 0 : burst + 1;
            end else begin
                expq.push_back(mfifo.pop_front());
                burst = 0;
            end
        end
    endtask

    initial begin
        int    n;
        int    base;
        word_t w, w2, h;
        word_t c [6];

        bus.cfg_req = 1'b0;
        bus.cfg_data = '0;
        repeat (3) @(negedge clk);

        check("rst_read_fifo_n", 64'(bus.read_fifo_n), 64'd1);
        check("rst_ld", 64'(bus.ld_tx_data), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_pending", 64'(bus.cfg_pending), 64'd0);
        check("rst_arb_busy", 64'(bus.arb_busy), 64'd0);
        check("rst_timeout", 64'(bus.tx_timeout), 64'd0);
        check("rst_drops", 64'(bus.cfg_drops), 64'd0);
        check("rst_words", 64'(bus.tx_words), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // FIFO drain of three words
        push_fifo(word_t'(1));
        push_fifo(word_t'(2));
        push_fifo(word_t'(3));
        edges_to_ld(n);
        check("fifo_latency", 64'(n), 64'(FL + 2));
        wait_tx(3, 300);
        wait_idle(100);
        for (int i = 0; i < 3; i++) check("drain_order", 64'(txq[i]), 64'(i + 1));
        check("drain_strobes", 64'(strobes), 64'd3);
        check("drain_words", 64'(bus.tx_words), STATS ? 64'd3 : 64'd0);

        // Config latency from request to load pulse
        base = txq.size();
        w = rnd();
        @(negedge clk);
        bus.cfg_data = w;
        bus.cfg_req = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_req = 1'b0;
        check("cfg_pending_set", 64'(bus.cfg_pending), 64'd1);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ld_tx_data === 1'b1) break;
        end
        check("cfg_latency", 64'(n), 64'd3);
        check("cfg_word", 64'(bus.tx_data), 64'(w));
        wait_idle(100);

        // Config and FIFO presented together: config first
        base = txq.size();
        w = rnd();
        w2 = rnd();
        @(negedge clk);
        force_busy = 1'b1;
        push_fifo(w2);
        bus.cfg_data = w;
        bus.cfg_req = 1'b1;
        @(negedge clk);
        bus.cfg_req = 1'b0;
        repeat (3) @(negedge clk);
        check("prio_held", 64'(txq.size()), 64'(base));
        force_busy = 1'b0;
        wait_tx(base + 2, 300);
        check("prio_first", 64'(txq[base]), 64'(w));
        check("prio_second", 64'(txq[base + 1]), 64'(w2));
        wait_idle(100);

        // Burst limit with six config words and a non-empty FIFO
        base = txq.size();
        mcfg.delete();
        mfifo.delete();
        for (int i = 0; i < 6; i++) begin
            c[i] = rnd();
            mcfg.push_back(c[i]);
        end
        @(negedge clk);
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = rnd();
            push_fifo(w);
            mfifo.push_back(w);
        end
        cfg_pulse(c[0]);
        force_busy = 1'b0;
        for (int k = 1; k < 6; k++) begin
            for (int i = 0; i < 200 && bus.cfg_pending; i++) @(negedge clk);
            check("burst_slot_free", 64'(bus.cfg_pending), 64'd0);
            cfg_pulse(c[k]);
        end
        model_order();
        wait_tx(base + 9, 1500);
        for (int i = 0; i < 9; i++) check("burst_order", 64'(txq[base + i]), 64'(expq[i]));
        wait_idle(100);

        // Drops while the UART stays busy, then the held word goes out
        @(negedge clk);
        force_busy = 1'b1;
        h = rnd();
        bus.cfg_data = h;
        bus.cfg_req = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            bus.cfg_data = rnd();
            @(negedge clk);
            if (i == 4) check("drops_5", 64'(bus.cfg_drops), STATS ? 64'd5 : 64'd0);
        end
        bus.cfg_req = 1'b0;
        @(negedge clk);
        check("drops_sat", 64'(bus.cfg_drops), STATS ? 64'd255 : 64'd0);
        check("drop_pending", 64'(bus.cfg_pending), 64'd1);
        base = txq.size();
        force_busy = 1'b0;
        wait_tx(base + 1, 100);
        check("held_word", 64'(txq[base]), 64'(h));
        wait_idle(100);

        // UART never goes busy: timeout, then normal service
        base = txq.size();
        uart_en = 1'b0;
        w = rnd();
        @(negedge clk);
        push_fifo(w);
        edges_to_ld(n);
        check("tmo_fifo_latency", 64'(n), 64'(FL + 2));
        repeat (TMO - 1) begin
            @(posedge clk);
            #1;
        end
        check("tmo_not_yet", 64'(bus.tx_timeout), 64'd0);
        @(posedge clk);
        #1;
        check("tmo_set", 64'(bus.tx_timeout), 64'd1);
        check("tmo_idle", 64'(bus.arb_busy), 64'd0);
        uart_en = 1'b1;
        w2 = rnd();
        @(negedge clk);
        push_fifo(w2);
        wait_tx(base + 2, 300);
        check("tmo_lost_word", 64'(txq[base]), 64'(w));
        check("tmo_next_word", 64'(txq[base + 1]), 64'(w2));
        check("tmo_sticky", 64'(bus.tx_timeout), 64'd1);
        wait_idle(100);

        // Reset while waiting on the FIFO
        base = txq.size();
        @(negedge clk);
        push_fifo(rnd());
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.read_fifo_n === 1'b0) break;
        end
        check("rst_strobe_seen", 64'(bus.read_fifo_n), 64'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_read_fifo_n", 64'(bus.read_fifo_n), 64'd1);
        check("mid_ld", 64'(bus.ld_tx_data), 64'd0);
        check("mid_pending", 64'(bus.cfg_pending), 64'd0);
        check("mid_arb_busy", 64'(bus.arb_busy), 64'd0);
        check("mid_timeout", 64'(bus.tx_timeout), 64'd0);
        check("mid_drops", 64'(bus.cfg_drops), 64'd0);
        check("mid_words", 64'(bus.tx_words), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_no_load", 64'(txq.size()), 64'(base));
        check("post_rst_idle", 64'(bus.arb_busy), 64'd0);
        check("no_read_when_empty", 64'(bad_reads), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
